// File: rtl/framebuffer_scanout.sv
`timescale 1ns/1ps
// Display-side raster scanner for a double-buffered framebuffer: generates timing,
// streams the front buffer with aligned de/sync, and owns the vblank buffer-swap handshake.
module framebuffer_scanout #(
  parameter int DISPLAY_WIDTH         = 100,
  parameter int DISPLAY_HEIGHT        = 100,
  parameter int FRAMEBUFFER_DATA_BITS = 16,
  parameter int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
  parameter int H_FRONT               = 4,
  parameter int H_SYNC                = 8,
  parameter int H_BACK                = 4,
  parameter int V_FRONT               = 2,
  parameter int V_SYNC                = 2,
  parameter int V_BACK                = 2,
  parameter bit SYNC_ACTIVE_LOW       = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             frame_start,
  input  logic                             frame_done,
  output logic                             display_buffer_sel,
  output logic [FRAMEBUFFER_ADDR_BITS-1:0] framebuffer_rd_addr,
  input  logic [FRAMEBUFFER_DATA_BITS-1:0] framebuffer_rd_data,
  output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data,
  output logic                             pixel_de,
  output logic                             hsync,
  output logic                             vsync,
  output logic [7:0]                       frame_repeat_count
);

  localparam int H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(DISPLAY_WIDTH);
  localparam logic [HW-1:0] HS_BEGIN = HW'(DISPLAY_WIDTH + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(DISPLAY_WIDTH + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(DISPLAY_HEIGHT);
  localparam logic [VW-1:0] V_SWAP   = VW'(DISPLAY_HEIGHT - 1);
  localparam logic [VW-1:0] VS_BEGIN = VW'(DISPLAY_HEIGHT + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(DISPLAY_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [FRAMEBUFFER_ADDR_BITS-1:0] ADDR_LAST =
    FRAMEBUFFER_ADDR_BITS'(DISPLAY_WIDTH * DISPLAY_HEIGHT - 1);
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  typedef enum logic [1:0] {ST_START, ST_RENDERING, ST_READY} state_t;

  logic [HW-1:0]                    h_cnt_reg;
  logic [VW-1:0]                    v_cnt_reg;
  logic [FRAMEBUFFER_ADDR_BITS-1:0] addr_reg;
  logic                             de_reg, hsync_reg, vsync_reg;
  logic                             done_prev_reg;
  state_t                           state_reg, state_next;
  logic                             sel_reg, sel_next;
  logic                             start_reg, start_next;
  logic [7:0]                       repeat_reg, repeat_next;

  logic h_end, v_end, active, h_sync_on, v_sync_on, swap_point, done_edge;

  assign h_end      = (h_cnt_reg == H_LAST);
  assign v_end      = (v_cnt_reg == V_LAST);
  assign active     = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign h_sync_on  = (h_cnt_reg >= HS_BEGIN) && (h_cnt_reg < HS_END);
  assign v_sync_on  = (v_cnt_reg >= VS_BEGIN) && (v_cnt_reg < VS_END);
  // Edge on which v_cnt steps into the first vblank line
  assign swap_point = h_end && (v_cnt_reg == V_SWAP);
  assign done_edge  = frame_done & ~done_prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      addr_reg  <= '0;
      de_reg    <= 1'b0;
      hsync_reg <= SYNC_IDLE;
      vsync_reg <= SYNC_IDLE;
    end else begin
      if (h_end) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= v_end ? '0 : v_cnt_reg + 1'b1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 1'b1;
      end
      // Wrapping on the last active pixel keeps the address inside the buffer through vblank
      if (h_end && v_end)
        addr_reg <= '0;
      else if (active)
        addr_reg <= (addr_reg == ADDR_LAST) ? '0 : addr_reg + 1'b1;
      de_reg    <= active;
      hsync_reg <= SYNC_ACTIVE_LOW ? ~h_sync_on : h_sync_on;
      vsync_reg <= SYNC_ACTIVE_LOW ? ~v_sync_on : v_sync_on;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_START;
      sel_reg       <= 1'b0;
      start_reg     <= 1'b0;
      repeat_reg    <= 8'd0;
      done_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      start_reg     <= start_next;
      repeat_reg    <= repeat_next;
      done_prev_reg <= frame_done;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    start_next  = 1'b0;
    repeat_next = repeat_reg;
    case (state_reg)
      ST_START: begin
        state_next = ST_RENDERING;
        start_next = 1'b1;
      end
      ST_RENDERING: begin
        if (swap_point && (repeat_reg != 8'hFF))
          repeat_next = repeat_reg + 8'd1;
        if (done_edge)
          state_next = ST_READY;
      end
      ST_READY: begin
        if (swap_point) begin
          sel_next   = ~sel_reg;
          start_next = 1'b1;
          state_next = ST_RENDERING;
        end
      end
      default: state_next = ST_START;
    endcase
  end

  assign framebuffer_rd_addr = addr_reg;
  // Read data lands one clock after its address, in step with the delayed strobe
  assign pixel_data          = de_reg ? framebuffer_rd_data : '0;
  assign pixel_de            = de_reg;
  assign hsync               = hsync_reg;
  assign vsync               = vsync_reg;
  assign frame_start         = start_reg;
  assign display_buffer_sel  = sel_reg;
  assign frame_repeat_count  = repeat_reg;

endmodule
